serial_calc_ctrl_v: RTL



---
 rtl/serial_calc_ctrl_v_pkg.sv | 14 +
 rtl/serial_calc_ctrl_v_if.sv | 24 ++
 rtl/unsigned_calc_v.sv | 12 +
 rtl/serial_calc_ctrl_v.sv | 98 +++++++++
 4 files changed

// File: rtl/serial_calc_ctrl_v_pkg.sv
// Shared encodings for the bit-serial add/sub controller.
// FSM states and operation codes.
package serial_calc_ctrl_v_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_calc_ctrl_v_if.sv
// Request/result bundle between a requester and the
// bit-serial calculator.
interface serial_calc_ctrl_v_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic             i_op;
  logic [WIDTH-1:0] i_x;
  logic [WIDTH-1:0] i_y;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_flag;

  modport master (
    output i_start, i_op, i_x, i_y,
    input  o_busy, o_done, o_result, o_flag
  );

  modport slave (
    input  i_start, i_op, i_x, i_y,
    output o_busy, o_done, o_result, o_flag
  );
endinterface

// File: rtl/unsigned_calc_v.sv
// One-bit full-adder cell.
// Shared by the serial controller across all bit positions.
module unsigned_calc_v (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_s,
  output logic o_carry
);
  assign o_s     = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));
endmodule

// File: rtl/serial_calc_ctrl_v.sv
// Bit-serial unsigned add/subtract controller, LSB first.
// One full-adder cell reused for WIDTH cycles per operation.
module serial_calc_ctrl_v
  import serial_calc_ctrl_v_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic i_clk,
  input logic i_rst,
  serial_calc_ctrl_v_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_x_sh;
  logic [WIDTH-1:0] r_y_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_op;
  logic             r_done;
  logic             r_flag;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_nx;

  unsigned_calc_v u_cell (
    .i_a     (r_x_sh[0]),
    .i_b     (r_y_sh[0]),
    .i_carry (r_carry),
    .o_s     (w_s),
    .o_carry (w_co)
  );

  // New sum bit enters at the MSB; earlier bits drift toward bit 0.
  assign w_sum_nx = (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // Busy is a plain decode of the state register.
  assign bus.o_busy   = (r_state == S_RUN);
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
  assign bus.o_flag   = r_flag;

  // Controller FSM with datapath shift registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_x_sh   <= '0;
      r_y_sh   <= '0;
      r_sum_sh <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_op     <= OP_ADD;
      r_done   <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_x_sh  <= bus.i_x;
            r_y_sh  <= (bus.i_op == OP_SUB) ? ~bus.i_y : bus.i_y;
            r_carry <= (bus.i_op == OP_SUB);
            r_op    <= bus.i_op;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_x_sh   <= r_x_sh >> 1;
          r_y_sh   <= r_y_sh >> 1;
          r_sum_sh <= w_sum_nx;
          r_carry  <= w_co;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result <= w_sum_nx;
            r_flag   <= (r_op == OP_ADD) ? w_co : ~w_co;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
